// File: rtl/mult_add_seq.sv
// mult_add_seq: rebuilds a dividend from its quotient, divisor and remainder,
// a = q*b + r, with a shift-add multiplier that handles one q bit per cycle.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   request a new operation; only looked at while idle
//   q, b, r unsigned quotient, divisor and remainder operands (N bits)
//   busy    high while an operation is in progress (RUN, ADJ, DONE)
//   done    one-cycle pulse when y, y_full and ovf take the new result
//   y       result truncated to N bits
//   y_full  full 2N-bit result
//   ovf     high when the result does not fit in N bits
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands are captured on the accepting edge
// RUN   | N cycles, one q bit per cycle added into the accumulator
// ADJ   | remainder added into the accumulator
// DONE  | result copied to the output registers, done pulsed

module mult_add_seq #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   q,
    input  logic [N-1:0]   b,
    input  logic [N-1:0]   r,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   y,
    output logic [2*N-1:0] y_full,
    output logic           ovf
);

    localparam int CW = (N < 2) ? 1 : $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ADJ  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [2*N-1:0] acc, acc_n;
    logic [N-1:0]   q_sh, q_sh_n;
    logic [N-1:0]   b_r, b_r_n;
    logic [N-1:0]   r_r, r_r_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           busy_n, done_n, ovf_n;
    logic [N-1:0]   y_n;
    logic [2*N-1:0] y_full_n;

    logic [2*N-1:0] b_ext;
    logic [2*N-1:0] r_ext;

    assign b_ext = {{N{1'b0}}, b_r};
    assign r_ext = {{N{1'b0}}, r_r};

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        q_sh_n   = q_sh;
        b_r_n    = b_r;
        r_r_n    = r_r;
        cnt_n    = cnt;
        done_n   = 1'b0;
        y_n      = y;
        y_full_n = y_full;
        ovf_n    = ovf;

        case (state)
            IDLE: begin
                if (start) begin
                    q_sh_n  = q;
                    b_r_n   = b;
                    r_r_n   = r;
                    acc_n   = '0;
                    cnt_n   = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                // 2N bits hold (2^N-1)^2 + 2^N-1, so the sum cannot wrap
                if (q_sh[0]) begin
                    acc_n = acc + (b_ext << cnt);
                end
                q_sh_n = q_sh >> 1;
                cnt_n  = cnt + 1'b1;
                if (cnt == CW'(N - 1)) begin
                    state_n = ADJ;
                end
            end
            ADJ: begin
                acc_n   = acc + r_ext;
                state_n = DONE;
            end
            DONE: begin
                y_full_n = acc;
                y_n      = acc[N-1:0];
                ovf_n    = |acc[2*N-1:N];
                done_n   = 1'b1;
                state_n  = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // busy is registered, so it follows the state being entered
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            q_sh   <= '0;
            b_r    <= '0;
            r_r    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            y      <= '0;
            y_full <= '0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            q_sh   <= q_sh_n;
            b_r    <= b_r_n;
            r_r    <= r_r_n;
            cnt    <= cnt_n;
            busy   <= busy_n;
            done   <= done_n;
            y      <= y_n;
            y_full <= y_full_n;
            ovf    <= ovf_n;
        end
    end

endmodule

// File: tb/tb_mult_add_seq.sv
module tb_mult_add_seq;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   q, b, r;
    logic           busy, done, ovf;
    logic [N-1:0]   y;
    logic [2*N-1:0] y_full;

    int errors = 0;
    int checks = 0;

    mult_add_seq #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .q      (q),
        .b      (b),
        .r      (r),
        .busy   (busy),
        .done   (done),
        .y      (y),
        .y_full (y_full),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start with the given operands and wait for done.
    // lat = number of rising edges from the start-sampling edge (counted as 1)
    // up to and including the edge that raises done; -1 if done never came.
    // held = 0 if y_full changed or busy dropped before done.
    task automatic pulse_and_wait(input logic [N-1:0] qi, input logic [N-1:0] bi,
                                  input logic [N-1:0] ri, output int lat, output bit held);
        logic [2*N-1:0] prev;
        prev  = y_full;
        held  = 1'b1;
        lat   = -1;
        q     = qi;
        b     = bi;
        r     = ri;
        start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
            if (y_full !== prev || busy !== 1'b1) held = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b1;
        q = 4'd5; b = 4'd5; r = 4'd5;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%0b want=0", busy); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got=%0b want=0", done); end
        checks++; if (y !== 4'd0)      begin errors++; $display("FAIL reset_y got=%0d want=0", y); end
        checks++; if (y_full !== 8'd0) begin errors++; $display("FAIL reset_y_full got=%0d want=0", y_full); end
        checks++; if (ovf !== 1'b0)    begin errors++; $display("FAIL reset_ovf got=%0b want=0", ovf); end
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_start_busy got=%0b want=0", busy); end
    endtask

    task automatic test_basic;
        int lat;
        bit held;
        pulse_and_wait(4'd2, 4'd5, 4'd3, lat, held);
        checks++; if (lat !== 7)        begin errors++; $display("FAIL basic_latency got=%0d want=7", lat); end
        checks++; if (held !== 1'b1)    begin errors++; $display("FAIL basic_hold_busy got=%0b want=1", held); end
        checks++; if (y !== 4'd13)      begin errors++; $display("FAIL basic_y got=%0d want=13", y); end
        checks++; if (y_full !== 8'd13) begin errors++; $display("FAIL basic_y_full got=%0d want=13", y_full); end
        checks++; if (ovf !== 1'b0)     begin errors++; $display("FAIL basic_ovf got=%0b want=0", ovf); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL basic_busy_at_done got=%0b want=0", busy); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL basic_done_one_cycle got=%0b want=0", done); end
        checks++; if (y_full !== 8'd13) begin errors++; $display("FAIL basic_y_full_held got=%0d want=13", y_full); end
    endtask

    task automatic test_max;
        int lat;
        bit held;
        pulse_and_wait(4'd15, 4'd15, 4'd15, lat, held);
        checks++; if (lat !== 7)         begin errors++; $display("FAIL max_latency got=%0d want=7", lat); end
        checks++; if (y_full !== 8'd240) begin errors++; $display("FAIL max_y_full got=%0d want=240", y_full); end
        checks++; if (y !== 4'd0)        begin errors++; $display("FAIL max_y got=%0d want=0", y); end
        checks++; if (ovf !== 1'b1)      begin errors++; $display("FAIL max_ovf got=%0b want=1", ovf); end
    endtask

    task automatic test_zero;
        int lat;
        bit held;
        pulse_and_wait(4'd0, 4'd0, 4'd7, lat, held);
        checks++; if (y_full !== 8'd7) begin errors++; $display("FAIL zero_y_full got=%0d want=7", y_full); end
        checks++; if (y !== 4'd7)      begin errors++; $display("FAIL zero_y got=%0d want=7", y); end
        checks++; if (ovf !== 1'b0)    begin errors++; $display("FAIL zero_ovf got=%0b want=0", ovf); end
        pulse_and_wait(4'd9, 4'd0, 4'd4, lat, held);
        checks++; if (y !== 4'd4)      begin errors++; $display("FAIL zero_b_y got=%0d want=4", y); end
        checks++; if (y_full !== 8'd4) begin errors++; $display("FAIL zero_b_y_full got=%0d want=4", y_full); end
    endtask

    task automatic test_ignore_start;
        int pulses, lat;
        logic [2*N-1:0] yf;
        logic [N-1:0]   yy;
        logic           ov;
        pulses = 0; lat = -1; yf = '0; yy = '0; ov = 1'b0;
        q = 4'd3; b = 4'd5; r = 4'd2;
        start = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                start = 1'b0;
                q = 4'd9; b = 4'd9; r = 4'd9;
            end else if (i == 2) begin
                start = 1'b1;
                q = 4'd1; b = 4'd1; r = 4'd1;
            end else if (i == 3) begin
                start = 1'b0;
            end
            if (done) begin
                pulses++;
                if (lat < 0) begin
                    lat = i;
                    yf  = y_full;
                    yy  = y;
                    ov  = ovf;
                end
            end
        end
        checks++; if (pulses !== 1)  begin errors++; $display("FAIL ignore_pulses got=%0d want=1", pulses); end
        checks++; if (lat !== 7)     begin errors++; $display("FAIL ignore_latency got=%0d want=7", lat); end
        checks++; if (yf !== 8'd17)  begin errors++; $display("FAIL ignore_y_full got=%0d want=17", yf); end
        checks++; if (yy !== 4'd1)   begin errors++; $display("FAIL ignore_y got=%0d want=1", yy); end
        checks++; if (ov !== 1'b1)   begin errors++; $display("FAIL ignore_ovf got=%0b want=1", ov); end
    endtask

    task automatic test_abort;
        int pulses, lat;
        bit held;
        pulses = 0;
        q = 4'd7; b = 4'd7; r = 4'd7;
        start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
            if (i == 1) start = 1'b0;
            if (i == 3) rst = 1'b1;
            if (i == 4) begin
                rst = 1'b0;
                checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL abort_busy got=%0b want=0", busy); end
                checks++; if (y_full !== 8'd0) begin errors++; $display("FAIL abort_y_full got=%0d want=0", y_full); end
                checks++; if (y !== 4'd0)      begin errors++; $display("FAIL abort_y got=%0d want=0", y); end
                checks++; if (ovf !== 1'b0)    begin errors++; $display("FAIL abort_ovf got=%0b want=0", ovf); end
            end
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_done got=%0d want=0", pulses); end
        pulse_and_wait(4'd4, 4'd3, 4'd1, lat, held);
        checks++; if (lat !== 7)        begin errors++; $display("FAIL after_abort_latency got=%0d want=7", lat); end
        checks++; if (y !== 4'd13)      begin errors++; $display("FAIL after_abort_y got=%0d want=13", y); end
        checks++; if (y_full !== 8'd13) begin errors++; $display("FAIL after_abort_y_full got=%0d want=13", y_full); end
    endtask

    task automatic test_back_to_back;
        int pulses;
        int edge_at [3];
        logic [2*N-1:0] got [3];
        int want [3];
        int idx [3];
        pulses = 0;
        idx[0] = 0; idx[1] = 7; idx[2] = 14;
        for (int k = 0; k < 3; k++) begin
            edge_at[k] = -1;
            got[k] = '0;
            want[k] = (((idx[k] * 3 + 1) % 16) * ((idx[k] * 5 + 2) % 16)) + ((idx[k] * 7 + 3) % 16);
        end
        for (int c = 0; c <= 23; c++) begin
            q = 4'((c * 3 + 1) % 16);
            b = 4'((c * 5 + 2) % 16);
            r = 4'((c * 7 + 3) % 16);
            start = (c <= 20);
            @(posedge clk);
            #1;
            if (done) begin
                if (pulses < 3) begin
                    edge_at[pulses] = c + 1;
                    got[pulses] = y_full;
                end
                pulses++;
            end
        end
        start = 1'b0;
        checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_pulses got=%0d want=3", pulses); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (got[k] !== 8'(want[k])) begin
                errors++; $display("FAIL b2b_result_%0d got=%0d want=%0d", k, got[k], want[k]);
            end
            checks++;
            if (edge_at[k] !== 7 * (k + 1)) begin
                errors++; $display("FAIL b2b_done_edge_%0d got=%0d want=%0d", k, edge_at[k], 7 * (k + 1));
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; q = '0; b = '0; r = '0;
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_add_seq.md
MULT_ADD_SEQ -- requirements
Module: mult_add_seq

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock, the only clock.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have port q, input, N bits: unsigned quotient operand.
REQ-006 The block SHALL have port b, input, N bits: unsigned divisor operand.
REQ-007 The block SHALL have port r, input, N bits: unsigned remainder operand.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-010 The block SHALL have port y, output, N bits: result truncated to N bits, (q*b + r) mod 2^N.
REQ-011 The block SHALL have port y_full, output, 2N bits: full result q*b + r.
REQ-012 The block SHALL have port ovf, output, 1 bit: high when q*b + r >= 2^N.

Function
REQ-013 The block SHALL compute a = q*b + r, reconstructing a dividend from quotient, divisor and remainder, using sequential shift-add, one q bit per cycle.
REQ-014 The FSM SHALL have the states IDLE, RUN, ADJ and DONE.
REQ-015 IDLE with start=1 SHALL register q, b and r, clear the accumulator, load bit counter = 0, and go to RUN.
REQ-016 IDLE with start=0 SHALL stay in IDLE and hold all outputs.
REQ-017 In RUN, each cycle: if shifted-q LSB=1, acc += (b zero-extended to 2N) << count; then shift q right and increment count.
REQ-018 RUN SHALL last exactly N cycles, then go to ADJ.
REQ-019 ADJ SHALL add r zero-extended to 2N bits to acc, then go to DONE.
REQ-020 The 2N-bit accumulator SHALL never wrap, since the maximum (2^N-1)^2 + 2^N-1 is less than 2^2N.
REQ-021 DONE SHALL register y_full=acc, y=acc[N-1:0] and ovf=|acc[2N-1:N], assert done for exactly one cycle, and go to IDLE.
REQ-022 done SHALL be high in the cycle following the (N+2)th rising edge after the edge that sampled start (N+3 cycles start-to-done).
REQ-023 busy SHALL be high in RUN, ADJ and DONE, and low in IDLE.
REQ-024 y, y_full and ovf SHALL hold their last values until the next DONE; they SHALL NOT change during RUN or ADJ.
REQ-025 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-026 start held high continuously SHALL begin a new operation on the first IDLE cycle after DONE; back-to-back throughput SHALL be one result per N+3 cycles.
REQ-027 Changes on q, b and r after the start-sampling edge SHALL NOT affect the result in progress.
REQ-028 b=0 or q=0 SHALL give y_full=r with no special case.
REQ-029 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, y=0, y_full=0, ovf=0, acc=0 and count=0.
REQ-031 rst SHALL take priority over start and over all FSM transitions.
REQ-032 rst asserted mid-operation (RUN, ADJ or DONE) SHALL abort the operation, discard the partial result and produce no done pulse.
REQ-033 The first start after rst deasserts SHALL be accepted normally.

Verification (N=4)
REQ-034 q=2, b=5, r=3, start pulse -> done exactly N+3=7 cycles later; y=13, y_full=13, ovf=0.
REQ-035 q=15, b=15, r=15 -> y_full=240, y=0, ovf=1.
REQ-036 q=0, b=0, r=7 -> y_full=7, y=7, ovf=0; also q=9, b=0, r=4 -> y=4.
REQ-037 q=3, b=5, r=2 accepted; a second start with q=1, b=1, r=1 at RUN cycle 2 -> ignored; result y_full=17, y=1, ovf=1, a single done pulse.
REQ-038 rst pulsed in RUN cycle 3 -> no done pulse, outputs 0; a following start with q=4, b=3, r=1 -> y=13, 7 cycles later.
REQ-039 start held high for 3 operations with q, b, r changed every cycle -> each result matches the operands sampled at its accepting edge; done pulses spaced 7 cycles apart.
